// File: rtl/seg_scan_if.sv
// ----------------------------------------------------------------------------
// seg_scan_if
//   Bundles the pattern inputs and the scanned-display outputs of seg_scan.
//
//   Signals:
//     en          scan enable (0 blanks the display and parks the counters)
//     bright      4-bit brightness, 0 = off, 15 = full on
//     seg0..seg7  per-digit segment patterns, active-low, bit7..0 = a..g,dp
//     seg_out     shared segment bus, active-low
//     an_out      digit enables, active-low, bit i = digit i
//     frame_tick  one-cycle pulse when the shadow registers load
//
//   Modports:
//     master  upstream side: drives patterns/controls, observes the display
//     slave   seg_scan side: consumes patterns/controls, drives the display
// ----------------------------------------------------------------------------
interface seg_scan_if;
    logic       en;
    logic [3:0] bright;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [7:0] seg3;
    logic [7:0] seg4;
    logic [7:0] seg5;
    logic [7:0] seg6;
    logic [7:0] seg7;
    logic [7:0] seg_out;
    logic [7:0] an_out;
    logic       frame_tick;

    modport master (
        output en, bright, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
        input  seg_out, an_out, frame_tick
    );

    modport slave (
        input  en, bright, seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
        output seg_out, an_out, frame_tick
    );
endinterface

// File: rtl/seg_scan.sv
// ----------------------------------------------------------------------------
// seg_scan
//   Time-multiplexes eight 8-bit segment patterns onto one shared segment bus
//   plus eight digit enables for scanned common-anode displays. Each digit
//   slot is CLK_DIV cycles long; the first BLANK cycles of every slot keep all
//   digits dark to stop ghosting. Brightness is a 4-bit PWM on the low nibble
//   of the slot counter. Patterns are copied into shadow registers once per
//   frame so a frame never mixes old and new patterns.
//
//   Ports:
//     clk    system clock
//     rst    asynchronous active-low reset (0 = reset asserted)
//     bus    seg_scan_if.slave (en, bright, seg0..seg7 in;
//            seg_out, an_out, frame_tick out)
//
//   Parameters:
//     CLK_DIV  clk cycles per digit slot (>= 2 and > BLANK)
//     BLANK    blanked cycles at the start of each slot (0 = no blanking)
// ----------------------------------------------------------------------------
module seg_scan #(
    parameter int CLK_DIV = 50000,
    parameter int BLANK   = 16
) (
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    // The PWM compare needs slot_cnt[3:0], so the counter is never narrower
    // than four bits even for tiny CLK_DIV values.
    localparam int CNT_W = ($clog2(CLK_DIV) < 4) ? 4 : $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] slot_cnt_r;
    logic [CNT_W-1:0] slot_nxt_s;
    logic [2:0]       dig_r;
    logic [2:0]       dig_nxt_s;
    logic             load_s;
    logic             digit_on_s;
    logic [7:0]       seg_in_s  [8];
    logic [7:0]       shadow_r  [8];
    logic [7:0]       seg_out_r;
    logic [7:0]       an_out_r;
    logic             frame_tick_r;

    assign seg_in_s[0] = bus.seg0;
    assign seg_in_s[1] = bus.seg1;
    assign seg_in_s[2] = bus.seg2;
    assign seg_in_s[3] = bus.seg3;
    assign seg_in_s[4] = bus.seg4;
    assign seg_in_s[5] = bus.seg5;
    assign seg_in_s[6] = bus.seg6;
    assign seg_in_s[7] = bus.seg7;

    // Next-state logic: slot/digit counting, frame start detection, state.
    always_comb begin
        state_nxt_s = ST_IDLE;
        slot_nxt_s  = '0;
        dig_nxt_s   = 3'd0;
        load_s      = 1'b0;
        if (bus.en == 1'b0) begin
            // Parked: counters held at zero, shadow registers untouched.
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Fresh start always begins a new frame at digit 0.
                    load_s = 1'b1;
                end
                ST_BLANK, ST_SHOW: begin
                    if (slot_cnt_r == LAST_C) begin
                        dig_nxt_s = dig_r + 3'd1;
                        load_s    = (dig_r == 3'd7);
                    end else begin
                        slot_nxt_s = slot_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        dig_nxt_s  = dig_r;
                    end
                end
                default: begin
                    load_s = 1'b1;
                end
            endcase
            // State mirrors where the next slot count sits in the slot.
            if (slot_nxt_s < BLANK_C) begin
                state_nxt_s = ST_BLANK;
            end else begin
                state_nxt_s = ST_SHOW;
            end
        end
    end

    // PWM gate: full brightness bypasses the compare so 4'hF is truly 100%.
    always_comb begin
        digit_on_s = 1'b0;
        if (state_r == ST_SHOW) begin
            digit_on_s = (bus.bright == 4'hF) || (slot_cnt_r[3:0] < bus.bright);
        end else begin
            digit_on_s = 1'b0;
        end
    end

    // State, slot counter and digit index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            slot_cnt_r <= '0;
            dig_r      <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            slot_cnt_r <= slot_nxt_s;
            dig_r      <= dig_nxt_s;
        end
    end

    // Frame-coherent shadow copy of the eight patterns plus the load pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= 8'hFF;
            end
            frame_tick_r <= 1'b0;
        end else begin
            if (load_s) begin
                for (int i = 0; i < 8; i++) begin
                    shadow_r[i] <= seg_in_s[i];
                end
            end
            frame_tick_r <= load_s;
        end
    end

    // Registered display drive; at most one anode low, segments dark when off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out_r <= 8'hFF;
            an_out_r  <= 8'hFF;
        end else if (digit_on_s) begin
            seg_out_r <= shadow_r[dig_r];
            an_out_r  <= ~(8'h01 << dig_r);
        end else begin
            seg_out_r <= 8'hFF;
            an_out_r  <= 8'hFF;
        end
    end

    assign bus.seg_out    = seg_out_r;
    assign bus.an_out     = an_out_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg_scan.sv
// ----------------------------------------------------------------------------
// tb_seg_scan
//   Directed self-checking bench for seg_scan with CLK_DIV=20, BLANK=4.
//   Outputs are sampled 1 ns after each rising edge. The variable cyc counts
//   rising edges since the first enabling edge; after edge E(base+j+1) the
//   outputs reflect counter position j of the frame (digit j/20, slot j%20).
// ----------------------------------------------------------------------------
module tb_seg_scan;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    seg_scan_if bus_if ();

    seg_scan #(
        .CLK_DIV (20),
        .BLANK   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", name, cyc, obs, exp);
        end
    endtask

    task automatic chk_disp(input string name, input logic [7:0] an_exp, input logic [7:0] seg_exp);
        chk({name, "_an"}, bus_if.an_out, an_exp);
        chk({name, "_seg"}, bus_if.seg_out, seg_exp);
    endtask

    task automatic chk_tick(input string name, input logic exp);
        chk(name, {7'd0, bus_if.frame_tick}, {7'd0, exp});
    endtask

    initial begin
        logic [7:0] an_e;
        logic [7:0] seg_e;
        logic       ok;
        checks   = 0;
        failures = 0;
        cyc      = 0;

        rst           = 1'b0;
        bus_if.en     = 1'b0;
        bus_if.bright = 4'hF;
        bus_if.seg0   = 8'h03;
        bus_if.seg1   = 8'h9F;
        bus_if.seg2   = 8'hFF;
        bus_if.seg3   = 8'hFF;
        bus_if.seg4   = 8'hFF;
        bus_if.seg5   = 8'hFF;
        bus_if.seg6   = 8'hFF;
        bus_if.seg7   = 8'hFF;

        // Reset state
        step(); step();
        chk_disp("reset", 8'hFF, 8'hFF);
        chk_tick("reset_tick", 1'b0);
        #3 rst = 1'b1;
        step(); step();
        chk_disp("idle", 8'hFF, 8'hFF);
        chk_tick("idle_tick", 1'b0);

        // Frame 0: first enabling edge is E0
        bus_if.en = 1'b1;
        step();
        cyc = 0;
        chk_tick("start_tick", 1'b1);
        chk_disp("start", 8'hFF, 8'hFF);
        for (int j = 1; j <= 4; j++) begin step(); chk_disp("d0_blank", 8'hFF, 8'hFF); end
        chk_tick("tick_one_cycle", 1'b0);
        for (int j = 5; j <= 20; j++) begin step(); chk_disp("d0_show", 8'hFE, 8'h03); end
        for (int j = 21; j <= 24; j++) begin step(); chk_disp("d1_blank", 8'hFF, 8'hFF); end
        for (int j = 25; j <= 40; j++) begin step(); chk_disp("d1_show", 8'hFD, 8'h9F); end
        run_to(159);
        chk_tick("tick_pre", 1'b0);
        step();
        chk_tick("tick_period", 1'b1);
        step();
        chk_tick("tick_post", 1'b0);

        // Frame 1: seg0 changed during digit 3, not visible until reload
        run_to(170);
        chk_disp("f1_d0", 8'hFE, 8'h03);
        run_to(225);
        bus_if.seg0 = 8'h25;
        run_to(320);
        chk_tick("f2_tick", 1'b1);

        // Frame 2: new seg0 visible; seg1 changed mid-frame stays hidden
        run_to(330);
        chk_disp("f2_d0_new", 8'hFE, 8'h25);
        bus_if.seg1 = 8'h11;
        bus_if.seg2 = 8'h0D;
        bus_if.seg5 = 8'h49;
        bus_if.seg6 = 8'h71;
        run_to(350);
        chk_disp("f2_d1_shadow", 8'hFD, 8'h9F);
        run_to(480);
        chk_tick("f3_tick", 1'b1);

        // Frame 3: PWM with bright=4 inside digit 2
        run_to(510);
        chk_disp("f3_d1_new", 8'hFD, 8'h11);
        bus_if.bright = 4'd4;
        run_to(520);
        for (int s = 0; s < 20; s++) begin
            step();
            if (s >= 4 && (s % 16) < 4) begin
                an_e = 8'hFB; seg_e = 8'h0D;
            end else begin
                an_e = 8'hFF; seg_e = 8'hFF;
            end
            chk_disp("pwm4", an_e, seg_e);
        end

        // bright=0: whole frame 4 dark, frame_tick still pulses
        bus_if.bright = 4'd0;
        run_to(640);
        chk_tick("dark_tick_start", 1'b1);
        for (int j = 0; j < 160; j++) begin
            step();
            chk_disp("dark", 8'hFF, 8'hFF);
        end
        chk_tick("dark_tick_end", 1'b1);

        // Frame 5: disable during digit 5 SHOW
        bus_if.bright = 4'hF;
        run_to(911);
        chk_disp("d5_show", 8'hDF, 8'h49);
        bus_if.en = 1'b0;
        step();
        chk_disp("dis_lag", 8'hDF, 8'h49);
        step();
        chk_disp("dis_dark", 8'hFF, 8'hFF);
        run_to(915);
        chk_disp("dis_hold", 8'hFF, 8'hFF);
        chk_tick("dis_tick", 1'b0);

        // Re-enable: fresh frame at digit 0
        run_to(920);
        bus_if.en = 1'b1;
        step();
        chk_tick("reen_tick", 1'b1);
        chk_disp("reen", 8'hFF, 8'hFF);
        for (int j = 0; j < 4; j++) begin step(); chk_disp("reen_blank", 8'hFF, 8'hFF); end
        chk_tick("reen_tick_end", 1'b0);
        step();
        chk_disp("reen_d0", 8'hFE, 8'h25);

        // Async reset during digit 6 SHOW
        run_to(1047);
        chk_disp("d6_show", 8'hBF, 8'h71);
        #2 rst = 1'b0;
        #1;
        chk_disp("async_rst", 8'hFF, 8'hFF);
        chk_tick("async_rst_tick", 1'b0);
        step();
        chk_disp("rst_hold", 8'hFF, 8'hFF);
        #3 rst = 1'b1;
        step();
        chk_tick("post_rst_tick", 1'b1);
        for (int j = 0; j < 4; j++) begin step(); chk_disp("post_rst_blank", 8'hFF, 8'hFF); end
        step();
        chk_disp("post_rst_d0", 8'hFE, 8'h25);

        // Invariants over 10 random frames
        for (int f = 0; f < 80; f++) begin
            bus_if.seg0   = 8'($urandom);
            bus_if.seg1   = 8'($urandom);
            bus_if.seg2   = 8'($urandom);
            bus_if.seg3   = 8'($urandom);
            bus_if.seg4   = 8'($urandom);
            bus_if.seg5   = 8'($urandom);
            bus_if.seg6   = 8'($urandom);
            bus_if.seg7   = 8'($urandom);
            bus_if.bright = 4'($urandom_range(15, 0));
            for (int k = 0; k < 20; k++) begin
                step();
                ok = ($countones(~bus_if.an_out) <= 1);
                chk("inv_one_anode", {7'd0, ok}, 8'd1);
                ok = (bus_if.an_out != 8'hFF) || (bus_if.seg_out == 8'hFF);
                chk("inv_dark_seg", {7'd0, ok}, 8'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Downstream stage of the per-digit segment-pattern generator.
- Takes the eight parallel 8-bit segment patterns and time-multiplexes them onto one shared segment bus plus eight digit-enable lines, for boards with scanned (common-anode) displays.
- Provides anti-ghosting blanking at the start of every digit slot, 4-bit PWM brightness, and frame-coherent shadowing so a frame never mixes old and new patterns.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot; must be >= 2 and > BLANK.
- BLANK, 16, cycles at the start of each slot with all digits off; 0 is legal (no blanking).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (0 = reset asserted)
- en  input  1  scan enable; 0 blanks the display and parks the counters
- bright  input  4  brightness; 0 = off, 15 = full on
- seg0..seg7  input  8 each  per-digit segment patterns, active-low, bit7..0 = a,b,c,d,e,f,g,dp
- seg_out  output  8  shared segment bus, active-low
- an_out  output  8  digit enables, active-low, bit i = digit i
- frame_tick  output  1  one-cycle pulse when the shadow registers load

Behaviour:
- Reset (rst=0, async):
  - seg_out=8'hFF, an_out=8'hFF, frame_tick=0.
  - All shadow registers = 8'hFF; dig=0, slot_cnt=0, state=IDLE.
- States:
  - IDLE: en=0 or just reset.
  - BLANK: slot_cnt < BLANK.
  - SHOW: slot_cnt >= BLANK.
- IDLE -> BLANK: first clk edge with en=1. That edge sets slot_cnt=0 and dig=0, loads shadow[i]<=seg_i for all i, and sets frame_tick<=1.
- Slot counting: slot_cnt increments each cycle.
  - At slot_cnt==CLK_DIV-1 it wraps to 0 and dig advances; dig wraps 7->0.
  - The 7->0 wrap reloads all eight shadow registers and pulses frame_tick for exactly one cycle.
  - Frame period = 8*CLK_DIV cycles.
- Shadow: seg_i changes mid-frame are not visible until the next frame load.
- Digit-on condition: state==SHOW && (bright==4'hF || slot_cnt[3:0] < bright). bright==0 keeps every digit dark, but counters still run and frame_tick still pulses.
- Outputs are registered, with 1-cycle latency from the counter state:
  - When the digit is on: an_out = ~(8'h01 << dig), seg_out = shadow[dig].
  - Otherwise: an_out = 8'hFF, seg_out = 8'hFF.
  - At most one an_out bit is ever low; seg_out is 8'hFF whenever an_out==8'hFF.
- en deasserted in any state: next edge -> IDLE with slot_cnt=0 and dig=0; outputs read 8'hFF from the following cycle. Shadow registers keep their values.
- Re-enable restarts at digit 0 with a fresh shadow load and a frame_tick pulse. There is no resume mid-frame.
- bright is sampled every cycle with no shadowing; a change takes effect on the next cycle.
- Reset mid-frame: immediate async return to the reset values above; the first edge after release with en=1 behaves as IDLE -> BLANK.

Test Plan (CLK_DIV=20, BLANK=4):
- Reset, en=1, bright=F, seg0=8'h03, seg1=8'h9F, others 8'hFF:
  - frame_tick high 1 cycle after the first edge.
  - 4 cycles an_out=FF, then 16 cycles an_out=FE with seg_out=03.
  - Then 4 cycles FF, then 16 cycles an_out=FD with seg_out=9F.
  - frame_tick period is 160 cycles.
- Change seg0 to 8'h25 during digit 3's slot -> digit 0 still shows 03 for the remainder of the frame; 25 appears after the next frame_tick.
- bright=4, seg2=8'h0D -> within digit 2's SHOW window, an_out=FB only when slot_cnt[3:0]<4, FF otherwise. bright=0 -> an_out stays FF for a full 160-cycle frame while frame_tick still pulses.
- en=0 during digit 5 SHOW -> outputs FF from 2 cycles later. en=1 at cycle N -> frame_tick in the cycle after the enabling edge; digit 0 appears after 4 blank cycles.
- rst asserted asynchronously mid-SHOW of digit 6 -> seg_out and an_out go to FF without waiting for a clk edge, frame_tick=0. After release, a fresh frame starts at digit 0.
- Invariant check over 10 random frames with random seg_i and bright: an_out always has at most one zero bit, and seg_out==FF whenever an_out==FF.
